// File: rtl/target_gen_multi.sv
// target_gen_multi
//   Game target generator. Each accepted round result (req) starts a draw
//   from a 2-tap-pair Fibonacci LFSR. A candidate (x, y) is kept only if it
//   lies inside the programmable maxima and differs from the current target.
//   After MAX_TRIES rejected candidates, a fallback target (x+1, y) is forced.
//   Loading a seed aborts any draw in progress.
//
//   Optional feature macro: TARGET_GEN_HIST_EN
//     When defined, the previous target is also remembered. Candidates equal
//     to it are rejected too. The fallback skips over it in the same cycle.
//
// Ports
//   clk           clock
//   reset_n       synchronous reset, active low
//   req           start a new draw (ignored while busy)
//   seed_load     load seed_in into the LFSR (zero maps to SEED); aborts draw
//   seed_in       seed value, LFSR_W bits
//   busy          high while a draw is in progress
//   target_valid  one-cycle pulse when target_x/target_y take a new value
//   target_x      current target x, X_W bits
//   target_y      current target y, Y_W bits
module target_gen_multi #(
    parameter int          X_W       = 5,
    parameter int          Y_W       = 5,
    parameter int          X_MAX     = 31,
    parameter int          Y_MAX     = 1,
    parameter int          LFSR_W    = 32,
    parameter logic [31:0] SEED      = 32'h0000_0001,
    parameter int          MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              busy,
    output logic              target_valid,
    output logic [X_W-1:0]    target_x,
    output logic [Y_W-1:0]    target_y
);

    // tries counts rejects so far; it only ever holds 0 .. MAX_TRIES-1.
    localparam int                TRY_W        = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]  LAST_TRY     = TRY_W'(MAX_TRIES - 1);
    localparam logic [X_W-1:0]    X_LIM        = X_W'(X_MAX);
    localparam logic [LFSR_W-1:0] SEED_L       = SEED[LFSR_W-1:0];
    // With a single legal point the repeat check would reject everything.
    localparam bit                SINGLE_POINT = (X_MAX == 0) && (Y_MAX == 0);

    generate
        if ((X_W < 1) || (Y_W < 1) ||
            (X_MAX < 0) || (X_MAX >= (1 << X_W)) ||
            (Y_MAX < 0) || (Y_MAX >= (1 << Y_W)) ||
            !((LFSR_W == 16) || (LFSR_W == 24) || (LFSR_W == 32)) ||
            (LFSR_W < X_W + Y_W) || (SEED_L == '0) || (MAX_TRIES < 1)) begin : g_bad_params
            $fatal(1, "target_gen_multi: illegal parameter set");
        end
    endgenerate

    typedef enum logic {IDLE, DRAW} state_t;

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic              fb;
    logic [TRY_W-1:0]  tries;
    logic [X_W-1:0]    cand_x;
    logic [Y_W-1:0]    cand_y;
    logic [X_W-1:0]    fall_x;
    logic [X_W-1:0]    commit_x;
    logic [Y_W-1:0]    commit_y;
    logic              accept;
    logic              commit;
`ifdef TARGET_GEN_HIST_EN
    logic [X_W-1:0]    prev_x;
    logic [Y_W-1:0]    prev_y;
`endif

    // Feedback taps (1-based positions) per supported width.
    generate
        if (LFSR_W == 32) begin : g_fb32
            assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
        end else if (LFSR_W == 24) begin : g_fb24
            assign fb = lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16];
        end else begin : g_fb16
            assign fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
        end
    endgenerate

    assign lfsr_next = {lfsr[LFSR_W-2:0], fb};
    assign cand_x    = lfsr_next[X_W-1:0];
    assign cand_y    = lfsr_next[X_W+Y_W-1:X_W];

    function automatic logic [X_W-1:0] wrap_inc(input logic [X_W-1:0] x);
        return (x == X_LIM) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        accept   = 1'b0;
        commit_x = cand_x;
        commit_y = cand_y;
        fall_x   = wrap_inc(target_x);
`ifdef TARGET_GEN_HIST_EN
        // One extra step is enough: only the previous target can block it.
        if ((fall_x == prev_x) && (target_y == prev_y)) begin
            fall_x = wrap_inc(fall_x);
        end
`endif
        if (SINGLE_POINT) begin
            accept   = 1'b1;
            commit_x = '0;
            commit_y = '0;
        end else begin
            // Compared as int so a full-range maximum is not a constant compare.
            accept = (int'(cand_x) <= X_MAX) && (int'(cand_y) <= Y_MAX) &&
                     !((cand_x == target_x) && (cand_y == target_y));
`ifdef TARGET_GEN_HIST_EN
            accept = accept && !((cand_x == prev_x) && (cand_y == prev_y));
`endif
            if (!accept) begin
                commit_x = fall_x;
                commit_y = target_y;
            end
        end
    end

    assign commit = (state == DRAW) && (accept || (tries == LAST_TRY));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: all state, including the LFSR, gets a defined reset value
            // so every draw sequence is reproducible from reset.
            state        <= IDLE;
            lfsr         <= SEED_L;
            tries        <= '0;
            busy         <= 1'b0;
            target_valid <= 1'b0;
            target_x     <= '0;
            target_y     <= '0;
`ifdef TARGET_GEN_HIST_EN
            prev_x       <= '0;
            prev_y       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the values from before this edge.
            target_valid <= 1'b0;
            if (seed_load) begin
                // Seed load wins over everything, including a pending req.
                lfsr  <= (seed_in == '0) ? SEED_L : seed_in;
                state <= IDLE;
                busy  <= 1'b0;
                tries <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            state <= DRAW;
                            busy  <= 1'b1;
                            tries <= '0;
                        end
                    end
                    DRAW: begin
                        lfsr <= lfsr_next;
                        if (commit) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            target_valid <= 1'b1;
                            target_x     <= commit_x;
                            target_y     <= commit_y;
`ifdef TARGET_GEN_HIST_EN
                            prev_x       <= target_x;
                            prev_y       <= target_y;
`endif
                        end else begin
                            tries <= tries + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_target_gen_multi.sv
// tb_target_gen_multi
//   Bench for target_gen_multi. Three instances share the inputs:
//     0: default parameters
//     1: X_MAX=0, Y_MAX=0 (single legal point)
//     2: X_MAX=12, MAX_TRIES=4 (fallback-heavy)
//   Directed sequences plus a vector table, then random traffic checked
//   against a transaction-level model of each instance.
`timescale 1ns/1ps
module tb_target_gen_multi;

    localparam int NDUT = 3;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        seed_load;
    logic [31:0] seed_in;
    logic        busy_o  [NDUT];
    logic        valid_o [NDUT];
    logic [4:0]  x_o     [NDUT];
    logic [4:0]  y_o     [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    target_gen_multi u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .seed_load(seed_load), .seed_in(seed_in),
        .busy(busy_o[0]), .target_valid(valid_o[0]), .target_x(x_o[0]), .target_y(y_o[0])
    );

    target_gen_multi #(.X_MAX(0), .Y_MAX(0)) u_zero (
        .clk(clk), .reset_n(reset_n), .req(req), .seed_load(seed_load), .seed_in(seed_in),
        .busy(busy_o[1]), .target_valid(valid_o[1]), .target_x(x_o[1]), .target_y(y_o[1])
    );

    target_gen_multi #(.X_MAX(12), .MAX_TRIES(4)) u_fb (
        .clk(clk), .reset_n(reset_n), .req(req), .seed_load(seed_load), .seed_in(seed_in),
        .busy(busy_o[2]), .target_valid(valid_o[2]), .target_x(x_o[2]), .target_y(y_o[2])
    );

    function automatic int xmax_of(input int i);
        case (i)
            0:       return 31;
            1:       return 0;
            default: return 12;
        endcase
    endfunction

    function automatic int ymax_of(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic int tries_of(input int i);
        return (i == 2) ? 4 : 8;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] m_lfsr  [NDUT];
    int          m_tx    [NDUT];
    int          m_ty    [NDUT];
    int          m_px    [NDUT];
    int          m_py    [NDUT];
    bit          m_busy  [NDUT];
    bit          m_valid [NDUT];
    int          m_left  [NDUT];
    int          m_rx    [NDUT];
    int          m_ry    [NDUT];
    logic [31:0] m_rlfsr [NDUT];

    // Parity of the tapped bits 32,22,2,1 shifted in at the bottom.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] taps;
        taps = 32'h8020_0003;
        return {v[30:0], ^(v & taps)};
    endfunction

    function automatic int wrap_inc(input int x, input int xm);
        return (x >= xm) ? 0 : x + 1;
    endfunction

    task automatic model_reset(input int i);
        m_lfsr[i]  = SEED;
        m_tx[i]    = 0;
        m_ty[i]    = 0;
        m_px[i]    = 0;
        m_py[i]    = 0;
        m_busy[i]  = 1'b0;
        m_valid[i] = 1'b0;
        m_left[i]  = 0;
    endtask

    // Resolve a whole draw up front: how many cycles, which target, final LFSR.
    task automatic model_start(input int i);
        logic [31:0] l;
        int xm, ym, mt, cx, cy, fx;
        bit ok;
        l  = m_lfsr[i];
        xm = xmax_of(i);
        ym = ymax_of(i);
        mt = tries_of(i);
        for (int k = 1; k <= mt; k++) begin
            l  = lfsr_step(l);
            cx = int'(l[4:0]);
            cy = int'(l[9:5]);
            if (xm == 0 && ym == 0) begin
                ok = 1'b1;
                cx = 0;
                cy = 0;
            end else begin
                ok = (cx <= xm) && (cy <= ym) && !(cx == m_tx[i] && cy == m_ty[i]);
`ifdef TARGET_GEN_HIST_EN
                ok = ok && !(cx == m_px[i] && cy == m_py[i]);
`endif
            end
            if (ok) begin
                m_left[i]  = k;
                m_rx[i]    = cx;
                m_ry[i]    = cy;
                m_rlfsr[i] = l;
                return;
            end
        end
        fx = wrap_inc(m_tx[i], xm);
`ifdef TARGET_GEN_HIST_EN
        if (fx == m_px[i] && m_ty[i] == m_py[i]) fx = wrap_inc(fx, xm);
`endif
        m_left[i]  = mt;
        m_rx[i]    = fx;
        m_ry[i]    = m_ty[i];
        m_rlfsr[i] = l;
    endtask

    // Expected outputs after the coming clock edge for the given inputs.
    task automatic model_cycle(input int i, input bit r, input bit sl, input logic [31:0] sin);
        m_valid[i] = 1'b0;
        if (sl) begin
            m_lfsr[i] = (sin == 32'd0) ? SEED : sin;
            m_busy[i] = 1'b0;
        end else if (!m_busy[i]) begin
            if (r) begin
                model_start(i);
                m_busy[i] = 1'b1;
            end
        end else begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
                m_busy[i]  = 1'b0;
                m_valid[i] = 1'b1;
                m_px[i]    = m_tx[i];
                m_py[i]    = m_ty[i];
                m_tx[i]    = m_rx[i];
                m_ty[i]    = m_ry[i];
                m_lfsr[i]  = m_rlfsr[i];
            end
        end
    endtask

    // ---------------- bench helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, return at
    // the following negedge where outputs are sampled.
    task automatic cycle(input bit r, input bit sl, input logic [31:0] sin);
        req       = r;
        seed_load = sl;
        seed_in   = sin;
        for (int i = 0; i < NDUT; i++) model_cycle(i, r, sl, sin);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req       = 1'b0;
        seed_load = 1'b0;
        seed_in   = 32'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NDUT; i++) model_reset(i);
    endtask

    typedef struct {
        bit          req;
        bit          sl;
        logic [31:0] sin;
        bit          busy;
        bit          valid;
        logic [4:0]  x;
        logic [4:0]  y;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Vector table for the default instance; each row: inputs for one
        // edge, then outputs expected right after that edge.
        vecs.push_back('{1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 5'd0, 5'd0}); // seed 1
        vecs.push_back('{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0}); // req, N+1 busy
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd3, 5'd0}); // N+2 (3,0)
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd0});
        vecs.push_back('{1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 5'd3, 5'd0}); // seed 1 again
        vecs.push_back('{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 5'd3, 5'd0}); // 3 rejected
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd3, 5'd0});
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd6, 5'd0}); // N+3 (6,0)
        vecs.push_back('{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 5'd6, 5'd0}); // start draw
        vecs.push_back('{1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 5'd6, 5'd0}); // abort, seed 0 -> SEED
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd6, 5'd0}); // no pulse
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd6, 5'd0});
`ifdef TARGET_GEN_HIST_EN
        vecs.push_back('{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 5'd6, 5'd0}); // 3 hits history
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd6, 5'd0}); // 6 hits current
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd6, 5'd0});
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd13, 5'd0});
`else
        vecs.push_back('{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 5'd6, 5'd0}); // LFSR back at SEED
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd3, 5'd0});
        vecs.push_back('{1'b1, 1'b1, 32'd1, 1'b0, 1'b0, 5'd3, 5'd0}); // req dropped
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd0});
`endif

        // ---- reset state of all instances ----
        do_reset();
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset%0d busy", i), busy_o[i], 0);
            check($sformatf("reset%0d valid", i), valid_o[i], 0);
            check($sformatf("reset%0d x", i), x_o[i], 0);
            check($sformatf("reset%0d y", i), y_o[i], 0);
        end

        // ---- single legal point: (0,0) on the first try ----
        cycle(1'b1, 1'b0, 32'd0);
        check("zero N+1 busy", busy_o[1], 1);
        check("zero N+1 valid", valid_o[1], 0);
        cycle(1'b0, 1'b0, 32'd0);
        check("zero N+2 busy", busy_o[1], 0);
        check("zero N+2 valid", valid_o[1], 1);
        check("zero N+2 x", x_o[1], 0);
        check("zero N+2 y", y_o[1], 0);
        cycle(1'b0, 1'b0, 32'd0);
        check("zero N+3 valid", valid_o[1], 0);

        // ---- vector table on the default instance ----
        do_reset();
        for (int v = 0; v < vecs.size(); v++) begin
            cycle(vecs[v].req, vecs[v].sl, vecs[v].sin);
            check($sformatf("vec%0d busy", v), busy_o[0], vecs[v].busy);
            check($sformatf("vec%0d valid", v), valid_o[0], vecs[v].valid);
            check($sformatf("vec%0d x", v), x_o[0], vecs[v].x);
            check($sformatf("vec%0d y", v), y_o[0], vecs[v].y);
        end

        // ---- fallback: candidates 13, 27, 22, 13 all rejected -> (1,0) ----
        do_reset();
        cycle(1'b0, 1'b1, 32'd6);
        cycle(1'b1, 1'b0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("fb N+%0d busy", k), busy_o[2], 1);
            check($sformatf("fb N+%0d valid", k), valid_o[2], 0);
            cycle(1'b0, 1'b0, 32'd0);
        end
        check("fb N+4 busy", busy_o[2], 1);
        cycle(1'b0, 1'b0, 32'd0);
        check("fb N+5 busy", busy_o[2], 0);
        check("fb N+5 valid", valid_o[2], 1);
        check("fb N+5 x", x_o[2], 1);
        check("fb N+5 y", y_o[2], 0);

        // ---- random traffic against the model ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit          r, sl;
            logic [31:0] sin;
            r   = ($urandom_range(0, 99) < 40);
            sl  = ($urandom_range(0, 99) < 4);
            sin = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            cycle(r, sl, sin);
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("rand c%0d dut%0d busy", c, i), busy_o[i], m_busy[i]);
                check($sformatf("rand c%0d dut%0d valid", c, i), valid_o[i], m_valid[i]);
                check($sformatf("rand c%0d dut%0d x", c, i), x_o[i], m_tx[i]);
                check($sformatf("rand c%0d dut%0d y", c, i), y_o[i], m_ty[i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/target_gen_multi.md
Name: target_gen_multi

Overview:
- Parametrised successor to the single-shot game target generator.
- Draws a new (x, y) target from an internal Galois-free Fibonacci LFSR each time a round result is accepted.
- Unlike the original: coordinates are bounded to programmable maxima by rejection sampling, a draw never repeats the current target, the seed is loadable, and a valid pulse marks each new target.
- Sits between the round/result logic and the display/hit-compare logic.

Parameters:
- X_W, 5, width of target_x.
- Y_W, 5, width of target_y.
- X_MAX, 31, largest legal x (0..2^X_W-1).
- Y_MAX, 1, largest legal y (0..2^Y_W-1).
- LFSR_W, 32, LFSR width; legal values 16, 24, 32 only; must be >= X_W+Y_W.
- SEED, 32'h0000_0001, reset/fallback seed (low LFSR_W bits used; must be nonzero).
- MAX_TRIES, 8, rejected draws before the fallback target is forced (>=1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active low.
- req  in  1  request new target (round result accepted); single-cycle pulse or level.
- seed_load  in  1  load seed_in into the LFSR.
- seed_in  in  LFSR_W  seed value.
- busy  out  1  high while a draw is in progress.
- target_valid  out  1  one-cycle pulse when target_x/target_y change.
- target_x  out  X_W  current target x.
- target_y  out  Y_W  current target y.

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on rising clk).
- Reset values: lfsr=SEED, target_x=0, target_y=0, target_valid=0, busy=0, try count=0, state IDLE.
- LFSR step: next = {lfsr[LFSR_W-2:0], fb}. fb taps (1-based):
  - 32: 32,22,2,1
  - 24: 24,23,22,17
  - 16: 16,15,13,4
- Candidate is taken from next: cx = next[X_W-1:0], cy = next[X_W+Y_W-1:X_W].
- States:
  - IDLE: busy=0. req=1 -> DRAW with try count=0. req is not latched otherwise.
  - DRAW: busy=1. Each cycle: lfsr<=next, candidate evaluated.
    - Accepted if cx<=X_MAX, cy<=Y_MAX, and (cx,cy) != (target_x,target_y).
    - Accept: register target, target_valid=1 next cycle, -> IDLE.
    - Reject: increment try count. If this was reject number MAX_TRIES, commit the fallback instead (valid pulses, -> IDLE).
    - Fallback: x = target_x+1 (wraps to 0 past X_MAX), y = target_y.
- Latency: req in cycle N -> earliest target_valid in cycle N+2; worst case N+1+MAX_TRIES.
- req while busy: ignored, not queued.
- seed_load has priority in every state:
  - lfsr<=seed_in, or SEED if seed_in==0 (zero lockup forbidden).
  - Any DRAW is aborted -> IDLE, no valid pulse, target unchanged.
  - seed_load and req in the same cycle: load only, req dropped.
- If X_MAX==0 and Y_MAX==0: repeat check disabled; every draw yields (0,0) on the first try.
- Out-of-range parameters (X_MAX>=2^X_W etc.) are illegal; simulation asserts at time 0.
- target_x/target_y change only in the same cycle target_valid rises.

Optional Feature:
- Macro: TARGET_GEN_HIST_EN.
- Defined:
  - A second register holds the previous target.
  - Candidates are also rejected if they equal it (no repeat within the last two targets).
  - Fallback advances x until it differs from both, wrapping at X_MAX, in a single cycle.
  - The history register resets to (0,0) and updates on every valid pulse.
- Undefined: only the current target is compared; no history register exists.

Test Plan:
- Reset: hold reset_n=0 two cycles -> target (0,0), valid=0, busy=0; with X_MAX=0, Y_MAX=0, req -> valid at N+2 with (0,0).
- Defaults, seed_load seed_in=1, then req at N -> LFSR next=0x3, target_valid at N+2 with (3,0), busy high in N+1 only.
- Repeat rejection: after the previous test, seed_load 1 again, req -> (3,0) rejected, next=0x6 -> (6,0) with valid at N+3.
- Fallback: X_MAX=12, MAX_TRIES=4, target (0,0), seed 6, req -> candidates 13, 27, 22, 13 rejected -> fallback (1,0), valid at N+5.
- Seed/abort: seed_load with seed_in=0 mid-DRAW -> lfsr=SEED, busy=0 next cycle, no valid pulse, target unchanged; req asserted together with seed_load is ignored.
- TARGET_GEN_HIST_EN: targets (3,0) then (6,0); reload seed 1 and req -> (3,0) is rejected (history) and (6,0) is rejected (current); the next candidate, 13, is accepted as (13,0).
